// File: rtl/tick_period_meter.sv
// -----------------------------------------------------------------------------
// tick_period_meter
//
// Measures the number of clk cycles between successive single-cycle ticks on
// tick_in and presents each measured period on a valid/ready handshake.
// A gap longer than MAX_GAP cycles ends the measurement with a one-cycle
// timeout pulse. A result that arrives while the output register is still
// full is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   clear         synchronous abort: FSM to IDLE, all flags cleared
//   tick_in       tick strobe, sampled every cycle
//   period        measured period in cycles (W bits)
//   period_valid  period holds an unconsumed result
//   period_ready  consumer accepts the result
//   busy          a measurement is in progress
//   timeout       one-cycle pulse when the gap exceeds MAX_GAP
//   overrun       sticky: a result was dropped because the buffer was full
// -----------------------------------------------------------------------------
module tick_period_meter #(
  parameter int W       = 16,
  parameter int MAX_GAP = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         tick_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         busy,
  output logic         timeout,
  output logic         overrun
);

  // MAX_GAP must be representable in the W-bit counter.
  if (MAX_GAP < 1 || longint'(MAX_GAP) > ((longint'(1) << W) - 1)) begin : g_bad_max_gap
    $fatal(1, "tick_period_meter: MAX_GAP out of range 1..2^W-1");
  end

  localparam logic [W-1:0] MAX_CNT = W'(MAX_GAP);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           result_fire;
  logic           timeout_d;
  logic           load;
  logic           drop;
  logic [W-1:0]   period_d;
  logic           period_valid_d;
  logic           overrun_d;

  // ---------------------------------------------------------------------------
  // Next-state logic for the measurement FSM and the output buffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_fire = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_in) begin
          state_d = MEASURE;
          cnt_d   = W'(1);
        end
      end
      MEASURE: begin
        if (tick_in) begin
          // Every tick closes one period and opens the next.
          result_fire = 1'b1;
          cnt_d       = W'(1);
        end else if (cnt_q == MAX_CNT) begin
          // Gap has reached the limit with no tick: abandon the measurement.
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // clear wins over the tick and over the handshake.
    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      result_fire = 1'b0;
      timeout_d   = 1'b0;
    end

    // One-entry output buffer: a result loads when the buffer is empty or is
    // being drained in this same cycle; otherwise it is dropped.
    load = result_fire && (!period_valid || period_ready);
    drop = result_fire && period_valid && !period_ready;

    period_d = load ? cnt_q : period;

    if (clear) begin
      period_valid_d = 1'b0;
    end else if (load) begin
      period_valid_d = 1'b1;
    end else if (period_valid && period_ready) begin
      period_valid_d = 1'b0;
    end else begin
      period_valid_d = period_valid;
    end

    overrun_d = clear ? 1'b0 : (overrun || drop);
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      timeout      <= timeout_d;
      overrun      <= overrun_d;
    end
  end

  assign busy = (state_q == MEASURE);

endmodule

// File: tb/tb_tick_period_meter.sv
// -----------------------------------------------------------------------------
// tb_tick_period_meter
//
// Self-checking bench for tick_period_meter. The reference model keeps the
// edge index of the last tick and derives periods and timeouts as plain
// differences of timestamps, plus a one-entry buffer for the handshake.
// -----------------------------------------------------------------------------
module tb_tick_period_meter;

  localparam int W       = 16;
  localparam int MAX_GAP = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         tick_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         period_ready;
  logic         busy;
  logic         timeout;
  logic         overrun;

  tick_period_meter #(.W(W), .MAX_GAP(MAX_GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .busy         (busy),
    .timeout      (timeout),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int           edge_idx = 0;
  bit           m_active;
  int           m_last;
  bit           m_valid;
  logic [W-1:0] m_period;
  bit           m_timeout;
  bit           m_overrun;

  function automatic logic [W+3:0] dut_vec();
    return {period_valid, period, busy, timeout, overrun};
  endfunction

  function automatic logic [W+3:0] model_vec();
    return {m_valid, m_period, m_active, m_timeout, m_overrun};
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_last    = 0;
    m_valid   = 1'b0;
    m_period  = '0;
    m_timeout = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Applies one clock edge worth of behaviour using timestamps.
  task automatic model_edge(input bit t, input bit r, input bit c);
    int           gap;
    bit           fire;
    logic [W-1:0] res;
    edge_idx++;
    fire = 1'b0;
    res  = '0;
    if (c) begin
      m_active  = 1'b0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_active) begin
        gap = edge_idx - m_last;
        if (t) begin
          fire   = 1'b1;
          res    = W'(gap);
          m_last = edge_idx;
        end else if (gap >= MAX_GAP) begin
          m_active  = 1'b0;
          m_timeout = 1'b1;
        end
      end else if (t) begin
        m_active = 1'b1;
        m_last   = edge_idx;
      end
      if (fire) begin
        if (!m_valid || r) begin
          m_valid  = 1'b1;
          m_period = res;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Drives one cycle of inputs, clocks the DUT and advances the model.
  // Outputs are stable 1 time unit after the edge when this returns.
  task automatic cycle(input bit t, input bit r, input bit c);
    tick_in      = t;
    period_ready = r;
    clear        = c;
    @(posedge clk);
    model_edge(t, r, c);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n        = 1'b0;
    clear        = 1'b0;
    tick_in      = 1'b0;
    period_ready = 1'b0;
    model_reset();
    #2;
    total++;
    if (dut_vec() !== '0) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), {(W+4){1'b0}});
    end
    // Ticks during reset must have no effect.
    tick_in = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec(), {(W+4){1'b0}});
    end
    @(negedge clk);
    tick_in = 1'b0;
    rst_n   = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_steady();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL steady_tick k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      if (k > 0) begin
        total++;
        if (period_valid !== 1'b1 || period !== W'(100) || busy !== 1'b1) begin
          bad++;
          $display("FAIL steady_period k=%0d got valid=%b period=%0d busy=%b exp valid=1 period=100 busy=1",
                   k, period_valid, period, busy);
        end
      end
      for (int i = 0; i < 99; i++) begin
        cycle(1'b0, 1'b1, 1'b0);
        total++;
        if (dut_vec() !== model_vec()) begin
          bad++;
          $display("FAIL steady_gap k=%0d i=%0d got=%h exp=%h", k, i, dut_vec(), model_vec());
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_boundaries();
    logic [W-1:0] got[$];
    int           seen_timeout;
    seen_timeout = 0;
    for (int i = 0; i <= 1003; i++) begin
      cycle((i < 4) || (i == 1003), 1'b1, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL bound_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (period_valid === 1'b1) got.push_back(period);
      if (timeout === 1'b1) seen_timeout++;
    end
    total++;
    if (got.size() != 4 || got[0] !== W'(1) || got[1] !== W'(1) || got[2] !== W'(1) ||
        got[3] !== W'(MAX_GAP) || seen_timeout != 0) begin
      bad++;
      $display("FAIL bound_results got n=%0d timeouts=%0d exp n=4 (1,1,1,%0d) timeouts=0",
               got.size(), seen_timeout, MAX_GAP);
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int to_count;
    int to_at;
    to_count = 0;
    to_at    = -1;
    for (int i = 0; i <= MAX_GAP + 4; i++) begin
      cycle(i == 0, 1'b1, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL timeout_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (timeout === 1'b1) begin
        to_count++;
        to_at = i;
      end
    end
    total++;
    if (to_count != 1 || to_at != MAX_GAP || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse got count=%0d at=%0d busy=%b exp count=1 at=%0d busy=0",
               to_count, to_at, busy, MAX_GAP);
    end
    // Next tick restarts from IDLE and produces no result.
    cycle(1'b1, 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1 || period_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_restart got busy=%b valid=%b timeout=%b exp busy=1 valid=0 timeout=0",
               busy, period_valid, timeout);
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    bit t;
    bit r;
    for (int i = 0; i <= 22; i++) begin
      t = (i == 0) || (i == 5) || (i == 10) || (i == 17) || (i == 20);
      r = (i == 12) || (i == 20) || (i == 21);
      cycle(t, r, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL bp_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (i >= 5 && i <= 11) begin
        total++;
        if (period_valid !== 1'b1 || period !== W'(5)) begin
          bad++;
          $display("FAIL bp_hold i=%0d got valid=%b period=%0d exp valid=1 period=5",
                   i, period_valid, period);
        end
      end
      if (i == 10) begin
        total++;
        if (overrun !== 1'b1) begin
          bad++;
          $display("FAIL bp_overrun got=%b exp=1", overrun);
        end
      end
      if (i == 20) begin
        total++;
        if (period_valid !== 1'b1 || period !== W'(3)) begin
          bad++;
          $display("FAIL bp_swap got valid=%b period=%0d exp valid=1 period=3", period_valid, period);
        end
      end
    end
    total++;
    if (period_valid !== 1'b0 || period !== W'(3) || overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_end got valid=%b period=%0d overrun=%b exp valid=0 period=3 overrun=1",
               period_valid, period, overrun);
    end
    // Accept and load in the same cycle with no prior overrun.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 6; i++) begin
      cycle((i == 0) || (i == 4) || (i == 6), i == 6, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL bp2_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    total++;
    if (period_valid !== 1'b1 || period !== W'(2) || overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp2_no_overrun got valid=%b period=%0d overrun=%b exp valid=1 period=2 overrun=0",
               period_valid, period, overrun);
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_clear_mid();
    bit t;
    for (int i = 0; i <= 16; i++) begin
      t = (i == 0) || (i == 3) || (i == 5) || (i == 6) || (i == 9) || (i == 16);
      cycle(t, i >= 7, i == 6);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL clr_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (i == 6) begin
        total++;
        if (busy !== 1'b0 || period_valid !== 1'b0 || overrun !== 1'b0 || period !== W'(3)) begin
          bad++;
          $display("FAIL clr_effect got busy=%b valid=%b overrun=%b period=%0d exp busy=0 valid=0 overrun=0 period=3",
                   busy, period_valid, overrun, period);
        end
      end
    end
    total++;
    if (period_valid !== 1'b1 || period !== W'(7)) begin
      bad++;
      $display("FAIL clr_after got valid=%b period=%0d exp valid=1 period=7", period_valid, period);
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    for (int i = 0; i <= 6; i++) begin
      cycle((i == 0) || (i == 4), 1'b0, 1'b0);
    end
    total++;
    if (period_valid !== 1'b1 || period !== W'(4) || busy !== 1'b1) begin
      bad++;
      $display("FAIL arst_setup got valid=%b period=%0d busy=%b exp valid=1 period=4 busy=1",
               period_valid, period, busy);
    end
    #4;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (dut_vec() !== '0) begin
      bad++;
      $display("FAIL arst_immediate got=%h exp=%h", dut_vec(), {(W+4){1'b0}});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      cycle((i == 0) || (i == 3), 1'b1, 1'b0);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL arst_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (i == 0) begin
        total++;
        if (period_valid !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL arst_first got valid=%b busy=%b exp valid=0 busy=1", period_valid, busy);
        end
      end
      if (i == 3) begin
        total++;
        if (period_valid !== 1'b1 || period !== W'(3)) begin
          bad++;
          $display("FAIL arst_second got valid=%b period=%0d exp valid=1 period=3", period_valid, period);
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int gap;
    for (int s = 0; s < 60; s++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_GAP - 5, MAX_GAP + 5))
                                        : int'($urandom_range(1, 12));
      for (int i = 1; i <= gap; i++) begin
        cycle(i == gap, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
        total++;
        if (dut_vec() !== model_vec()) begin
          bad++;
          $display("FAIL rand_cycle s=%0d i=%0d got=%h exp=%h", s, i, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_boundaries();
    test_timeout();
    test_backpressure();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Receive-side companion to the modular tick counter: it watches a single-cycle tick stream, such as a counter's carry-out, and measures the number of `clk` cycles between successive ticks. Each measured period goes out on a valid/ready handshake. The block also flags lost ticks with a timeout and dropped results with an overrun flag. It sits downstream of rate generators, where it checks tick cadence and feeds period values to monitoring or control logic.

## Interface
Parameters:
- `W`, default 16: width of the period counter and the result.
- `MAX_GAP`, default 1000: largest legal period in cycles. Required range 1 ≤ `MAX_GAP` ≤ 2^W−1; elaboration fails outside it.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clear`, input, 1: synchronous abort. Resets the FSM and all flags.
- `tick_in`, input, 1: tick strobe, sampled every cycle. High on consecutive cycles counts as consecutive ticks.
- `period`, output, W: measured period in cycles.
- `period_valid`, output, 1: `period` holds an unconsumed result.
- `period_ready`, input, 1: consumer accepts the result.
- `busy`, output, 1: a measurement is in progress (state MEASURE).
- `timeout`, output, 1: one-cycle pulse when the gap exceeds `MAX_GAP`.
- `overrun`, output, 1: sticky; a result was dropped because the output register was still full.

## Operation
- State machine:
  - IDLE: waiting for a first tick.
  - MEASURE: counting cycles since the last tick.
- Period definition: ticks at cycles t0 and t1 give a period of t1−t0. Back-to-back ticks give 1.
- In IDLE:
  - `tick_in`=1: go to MEASURE, `cnt`←1.
  - Otherwise: `cnt` stays 0.
- In MEASURE, when `tick_in`=1:
  - A result equal to `cnt` is produced.
  - `cnt`←1 and the FSM stays in MEASURE, so every tick closes one period and opens the next.
- In MEASURE, when `tick_in`=0 and `cnt` < `MAX_GAP`: `cnt`←`cnt`+1.
- In MEASURE, when `tick_in`=0 and `cnt` == `MAX_GAP`:
  - `timeout` pulses next cycle, FSM goes to IDLE, `cnt`←0, and no result is produced.
  - A tick arriving exactly when `cnt` == `MAX_GAP` is a valid result of `MAX_GAP`.
- Width: `cnt` never exceeds `MAX_GAP`, so no wrap or saturation logic is needed.
- Output register: a one-entry buffer.
  - A result loads into it when it is empty, or when the current result is being accepted (`period_valid`&&`period_ready`) in the same cycle.
  - Otherwise the result is dropped, `overrun` is set, and the held `period` is unchanged.
  - While `period_valid`=1 and `period_ready`=0, `period` is stable.
  - On acceptance with no new result, `period_valid` falls next cycle. `period` keeps its last value.
- `clear` (synchronous) takes priority over `tick_in` and over the handshake. Next cycle:
  - FSM is IDLE, `cnt`=0.
  - `period_valid`=0, `overrun`=0, `timeout`=0.
  - `period` is unchanged.
- `overrun` is cleared only by `clear` or reset.

## Timing
- Reset values: `period`=0, `period_valid`=0, `busy`=0, `timeout`=0, `overrun`=0; FSM in IDLE, `cnt`=0.
- Reset mid-measurement discards the count and any pending result immediately (asynchronous).
- Result latency: a tick in cycle t1 gives `period_valid`=1 with the new `period` at t1+1.
- `busy` goes 1 the cycle after the first tick. It goes 0 the cycle after a timeout or `clear`.
- `timeout` is high exactly one cycle, at t0+`MAX_GAP`+1 for a last tick at t0 with no further tick. `busy` falls in the same cycle.
- Throughput: one result per cycle is sustained when `period_ready` is held at 1.
- `period_ready` may be asserted with `period_valid`=0; it has no effect.
- No combinational path from `tick_in` or `period_ready` to any output.

## Test plan
- **Steady cadence.** Ticks every 100 cycles (counter with M=100, en=1), `period_ready`=1, `MAX_GAP`=1000. Expect the first result 100, then 100 for every tick; `busy`=1 throughout; `timeout`=0.
- **Boundaries.** `tick_in` held high for 4 cycles, then a tick exactly 1000 cycles later. Expect results 1, 1, 1, then 1000; no timeout.
- **Timeout.** A single tick at cycle 10, then none. Expect `timeout` high at cycle 1011 only, `busy`=0 from 1011, no `period_valid`. The next tick restarts from IDLE with no result.
- **Backpressure.** `period_ready`=0, ticks every 5 cycles. Expect:
  - The first result 5 is held stable.
  - The second tick's result is dropped and `overrun`=1.
  - `period_ready`=1 for one cycle → the held 5 is accepted.
  - An acceptance in the same cycle as a new result loads the new result with no new overrun.
- **Clear mid-measure.** `clear` on the same cycle as a tick, with a result pending. Next cycle: IDLE, `period_valid`=0, `overrun`=0, and that tick ignored. The following two ticks 7 cycles apart give 7.
- **Async reset.** `rst_n` asserted mid-measurement with a result pending. All outputs go to their reset values immediately. After release, the first result needs two fresh ticks.
